// File: rtl/wash_phase_timer.sv
// wash_phase_timer: times soak/wash/rinse/spin phases and returns one-cycle done pulses (optional pause via WASH_PHASE_TIMER_PAUSE_EN)
module wash_phase_timer #(
  parameter int TICK_DIV = 100,
  parameter int SOAK_T   = 20,
  parameter int WASH_T   = 30,
  parameter int RINSE_T  = 15,
  parameter int SPIN_T   = 10,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
`ifdef WASH_PHASE_TIMER_PAUSE_EN
  input  logic          pause,
`endif
  input  logic          soak,
  input  logic          wash,
  input  logic          rinse,
  input  logic          spin,
  input  logic          mode1,
  input  logic          mode2,
  input  logic          mode3,
  output logic          soaked,
  output logic          washed,
  output logic          rinsed,
  output logic          spun,
  output logic          busy,
  output logic [CW-1:0] remaining,
  output logic          phase_err
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d, rem_q, dur, wash_dur;
  logic [1:0]    ph_q, ph_d, ph_new;
  logic [3:0]    cmd, done_q;
  logic [2:0]    ncmd;
  logic          multi, tick, frz, busy_q, err_q;
  assign cmd      = {spin, rinse, wash, soak};
  assign ncmd     = 3'(soak) + 3'(wash) + 3'(rinse) + 3'(spin);
  assign multi    = ncmd > 3'd1;
  assign ph_new   = wash ? 2'd1 : rinse ? 2'd2 : spin ? 2'd3 : 2'd0;
  assign wash_dur = (mode2 & !mode1 & !mode3) ? CW'(2 * WASH_T) :
                    (mode3 & !mode1 & !mode2) ? CW'(3 * WASH_T) : CW'(WASH_T);
  assign dur      = ph_new == 2'd0 ? CW'(SOAK_T) : ph_new == 2'd1 ? wash_dur :
                    ph_new == 2'd2 ? CW'(RINSE_T) : CW'(SPIN_T);
  assign tick     = pre_q == PW'(TICK_DIV - 1);
`ifdef WASH_PHASE_TIMER_PAUSE_EN
  assign frz = pause;
`else
  assign frz = 1'b0;
`endif
  // Next state: conflicting commands force IDLE, a dropped command aborts or releases
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    if (multi) state_d = IDLE;
    else case (state_q)
      IDLE: if (ncmd == 3'd1) begin
        state_d = RUN;
        ph_d    = ph_new;
        pre_d   = '0;
        cnt_d   = dur;
      end
      RUN: if (!cmd[ph_q]) state_d = IDLE;
      else if (!frz) begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (tick && cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: state_d = HOLD;
      HOLD: if (!cmd[ph_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State, timer and registered outputs derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      done_q  <= state_d == DONE ? 4'b1 << ph_d : '0;
      busy_q  <= state_d == RUN;
      rem_q   <= state_d == RUN ? cnt_d : '0;
      err_q   <= multi;
    end
  end
  assign {spun, rinsed, washed, soaked} = done_q;
  assign busy      = busy_q;
  assign remaining = rem_q;
  assign phase_err = err_q;
endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer: scoreboard bench for wash_phase_timer (pause case under WASH_PHASE_TIMER_PAUSE_EN)
module tb_wash_phase_timer;
  localparam int TD = 4, CW = 16;
  typedef struct { int vec; int cyc; } exp_t;
  logic clk = 0, rst = 1, pause = 0;
  logic soak = 0, wash = 0, rinse = 0, spin = 0, mode1 = 0, mode2 = 0, mode3 = 0;
  logic soaked, washed, rinsed, spun, busy, phase_err;
  logic [CW-1:0] remaining;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb[$];
  wash_phase_timer #(.TICK_DIV(TD), .SOAK_T(2), .WASH_T(2), .RINSE_T(1), .SPIN_T(3), .CW(CW)) dut (
    .clk(clk), .rst(rst),
`ifdef WASH_PHASE_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .soak(soak), .wash(wash), .rinse(rinse), .spin(spin),
    .mode1(mode1), .mode2(mode2), .mode3(mode3),
    .soaked(soaked), .washed(washed), .rinsed(rinsed), .spun(spun),
    .busy(busy), .remaining(remaining), .phase_err(phase_err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d cyc=%0d", tag, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int vec, input int d, input int extra);
    exp_t e;
    e.vec = vec;
    e.cyc = cyc + 1 + d * TD + extra;
    sb.push_back(e);
  endtask
  task automatic run_phase(input logic [3:0] vec, input logic [2:0] m, input int d);
    {spin, rinse, wash, soak} = vec;
    {mode3, mode2, mode1} = m;
    push(int'(vec), d, 0);
    step(1);
    chk("busy_run", int'(busy), 1);
    chk("rem_start", int'(remaining), d);
    chk("err_run", int'(phase_err), 0);
    step(d * TD);
    chk("busy_done", int'(busy), 0);
    step(1);
    {spin, rinse, wash, soak} = 4'b0;
    step(1);
    chk("rem_idle", int'(remaining), 0);
    chk("busy_idle", int'(busy), 0);
  endtask
  always @(posedge clk) begin
    #2;
    if ({spun, rinsed, washed, soaked} != 4'b0) begin
      if (sb.size() == 0) chk("unexp_pulse", int'({spun, rinsed, washed, soaked}), 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_vec", int'({spun, rinsed, washed, soaked}), e.vec);
        chk("pulse_cyc", cyc, e.cyc);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_err", int'(phase_err), 0);
    chk("rst_pulse", int'({spun, rinsed, washed, soaked}), 0);
    rst = 0;
    step(1);
    soak = 1;
    push(1, 2, 0);
    step(1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_rem2", int'(remaining), 2);
    step(4);
    chk("t1_rem1", int'(remaining), 1);
    step(4);
    chk("t1_busy_done", int'(busy), 0);
    step(2);
    chk("t1_hold_busy", int'(busy), 0);
    soak = 0;
    step(2);
    run_phase(4'b0010, 3'b100, 6);
    run_phase(4'b0010, 3'b010, 4);
    run_phase(4'b0010, 3'b101, 2);
    run_phase(4'b0001, 3'b000, 2);
    run_phase(4'b0010, 3'b001, 2);
    run_phase(4'b0100, 3'b000, 1);
    run_phase(4'b1000, 3'b000, 3);
    soak = 1;
    step(3);
    soak = 0;
    step(1);
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_rem", int'(remaining), 0);
    step(3 * TD);
    soak = 1;
    wash = 1;
    step(1);
    chk("t5_err", int'(phase_err), 1);
    chk("t5_busy", int'(busy), 0);
    step(3);
    chk("t5_err_held", int'(phase_err), 1);
    chk("t5_busy_held", int'(busy), 0);
    run_phase(4'b0001, 3'b000, 2);
    spin = 1;
    step(5);
    chk("t6_busy", int'(busy), 1);
    rst = 1;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_rem", int'(remaining), 0);
    chk("t6_rst_pulse", int'({spun, rinsed, washed, soaked}), 0);
    spin = 0;
    step(1);
    rst = 0;
    step(2);
`ifdef WASH_PHASE_TIMER_PAUSE_EN
    soak = 1;
    push(1, 2, 5);
    step(3);
    pause = 1;
    step(5);
    chk("pz_busy", int'(busy), 1);
    pause = 0;
    step(11);
    soak = 0;
    step(2);
`endif
    step(4 * TD);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
